// File: rtl/booth_multiplier_r4_if.sv
// Operand/result bundle for the radix-4 Booth multiplier.
// The master drives operands and start; the slave returns busy, done and prod.
interface booth_multiplier_r4_if #(
  parameter int unsigned WIDTH = 8
);
  logic               start;
  logic               signed_mode;
  logic [WIDTH-1:0]   mc;
  logic [WIDTH-1:0]   mp;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] prod;

  modport master (
    output start,
    output signed_mode,
    output mc,
    output mp,
    input  busy,
    input  done,
    input  prod
  );

  modport slave (
    input  start,
    input  signed_mode,
    input  mc,
    input  mp,
    output busy,
    output done,
    output prod
  );
endinterface

// File: rtl/booth_multiplier_r4.sv
// Sequential radix-4 (modified Booth) multiplier, two multiplier bits per clock.
// Operands are extended by two bits so one datapath serves signed and unsigned modes.
module booth_multiplier_r4 #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  booth_multiplier_r4_if.slave bus
);

  localparam int unsigned ITER = WIDTH / 2 + 1;
  localparam int unsigned CW   = $clog2(ITER + 1);
  localparam int unsigned QW   = WIDTH + 2;
  localparam int unsigned AW   = WIDTH + 3;
  localparam int unsigned SW   = AW + QW + 1;

  generate
    if (WIDTH < 4 || (WIDTH % 2) != 0) begin : g_bad_width
      $error("booth_multiplier_r4: WIDTH must be even and >= 4");
    end
  endgenerate

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [QW-1:0]      m_q, m_d;
  logic [AW-1:0]      a_q, a_d;
  logic [QW-1:0]      q_q, q_d;
  logic               q1_q, q1_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;

  logic [QW-1:0]      mc_ext;
  logic [QW-1:0]      mp_ext;
  logic [AW-1:0]      m_one;
  logic [AW-1:0]      m_two;
  logic [AW-1:0]      addend;
  logic               sub;
  logic [AW-1:0]      sum;
  logic [SW-1:0]      shifted;
  logic               last_iter;

  // Two guard bits make the unsigned maximum representable as a positive signed value.
  assign mc_ext = bus.signed_mode ? {{2{bus.mc[WIDTH-1]}}, bus.mc} : {2'b00, bus.mc};
  assign mp_ext = bus.signed_mode ? {{2{bus.mp[WIDTH-1]}}, bus.mp} : {2'b00, bus.mp};

  assign m_one = {m_q[QW-1], m_q};
  assign m_two = {m_q, 1'b0};

  always_comb begin
    addend = '0;
    sub    = 1'b0;
    case ({q_q[1:0], q1_q})
      3'b001, 3'b010: addend = m_one;
      3'b011:         addend = m_two;
      3'b100: begin
        addend = m_two;
        sub    = 1'b1;
      end
      3'b101, 3'b110: begin
        addend = m_one;
        sub    = 1'b1;
      end
      default:        addend = '0;
    endcase
  end

  assign sum = sub ? (a_q + (~addend) + AW'(1)) : (a_q + addend);

  // Arithmetic shift of {A,Q,Q_1} by two, replicating the new accumulator sign.
  assign shifted = {{2{sum[AW-1]}}, sum, q_q, q1_q} >> 2;

  assign last_iter = (cnt_q == CW'(ITER - 1));

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    a_d     = a_q;
    q_d     = q_q;
    q1_d    = q1_q;
    cnt_d   = cnt_q;
    prod_d  = prod_q;
    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          m_d     = mc_ext;
          q_d     = mp_ext;
          a_d     = '0;
          q1_d    = 1'b0;
          cnt_d   = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        a_d   = shifted[SW-1:QW+1];
        q_d   = shifted[QW:1];
        q1_d  = shifted[0];
        cnt_d = cnt_q + CW'(1);
        if (last_iter) begin
          prod_d  = shifted[2*WIDTH:1];
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      m_q     <= '0;
      a_q     <= '0;
      q_q     <= '0;
      q1_q    <= 1'b0;
      cnt_q   <= '0;
      prod_q  <= '0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      a_q     <= a_d;
      q_q     <= q_d;
      q1_q    <= q1_d;
      cnt_q   <= cnt_d;
      prod_q  <= prod_d;
    end
  end

  assign bus.busy = (state_q == RUN);
  assign bus.done = (state_q == DONE);
  assign bus.prod = prod_q;

endmodule
